mem_port_arbiter: RTL and testbench

//  Shares the single instruction_and_data memory port between instruction fetch (IF) and execute load/store (EX).

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_lat_timer.sv | 35 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state and read-owner encodings, and the latency timer width.
package mem_port_arbiter_pkg;

  localparam int LAT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_EX = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// Loadable down-counter for the memory read latency. done_o is high while the count is 1,
// which is the cycle in which the read data is valid.
module mem_arb_lat_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch (IF) and execute (EX). EX has priority.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX consecutive EX grants while IF waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_gnt,
  output logic              ex_rvalid,
  output logic [DATA_W-1:0] ex_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ex_rvalid_q, ex_rvalid_d;
  logic              timer_load;
  logic              timer_done;
  logic              force_if;

  mem_arb_lat_timer u_lat_timer (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (timer_load),
    .load_val_i(LAT_LOAD),
    .done_o    (timer_done)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = if_req && (starve_cnt_q == SC_W'(STARVE_MAX));

  // Counts EX wins that IF lost; any IF grant or IF going quiet restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ex_gnt) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
    if_rvalid_d = 1'b0;
    ex_rvalid_d = 1'b0;
    if_gnt      = 1'b0;
    ex_gnt      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    timer_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_req && !force_if) begin
          ex_gnt   = 1'b1;
          mem_addr = ex_addr;
          if (ex_we) begin
            mem_we    = 1'b1;
            mem_wdata = ex_wdata;
          end else begin
            mem_re     = 1'b1;
            owner_d    = OWN_EX;
            timer_load = 1'b1;
            state_d    = ST_WAIT;
          end
        end else if (if_req) begin
          if_gnt     = 1'b1;
          mem_addr   = if_addr;
          mem_re     = 1'b1;
          owner_d    = OWN_IF;
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Data is captured now; rvalid and the return to IDLE land together next cycle.
        if (timer_done) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end else begin
            ex_rdata_d  = mem_rdata;
            ex_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      ex_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ex_rvalid_q <= ex_rvalid_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign ex_rvalid = ex_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;
  assign stall     = (if_req & ~if_gnt) | (ex_req & ~ex_gnt) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        if_req, ex_req, ex_we;
  logic [31:0] if_addr, ex_addr, ex_wdata;

  logic        a_if_gnt, a_if_rvalid, a_ex_gnt, a_ex_rvalid, a_mem_we, a_mem_re, a_stall;
  logic [31:0] a_if_rdata, a_ex_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_ex_gnt, b_ex_rvalid, b_mem_we, b_mem_re, b_stall;
  logic [31:0] b_if_rdata, b_ex_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(a_ex_gnt), .ex_rvalid(a_ex_rvalid), .ex_rdata(a_ex_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_rdata(a_mem_rdata), .stall(a_stall)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(b_ex_gnt), .ex_rvalid(b_ex_rvalid), .ex_rdata(b_ex_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(b_mem_rdata), .stall(b_stall)
  );

  // Memory models: unwritten words read back as init_val(address); read data lags mem_re by MEM_LAT cycles.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {24'hA5C300, a};
  endfunction

  bit [31:0] mem_a [256];
  bit        wr_a  [256];
  bit [31:0] mem_b [256];
  bit        wr_b  [256];
  logic [7:0] ra_q;
  logic [7:0] rb_q [3];

  always @(posedge clk) begin
    if (a_mem_we) begin
      mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      wr_a[a_mem_addr[7:0]]  <= 1'b1;
    end
    ra_q <= a_mem_addr[7:0];
    if (b_mem_we) begin
      mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
      wr_b[b_mem_addr[7:0]]  <= 1'b1;
    end
    rb_q[0] <= b_mem_addr[7:0];
    rb_q[1] <= rb_q[0];
    rb_q[2] <= rb_q[1];
  end

  assign a_mem_rdata = wr_a[ra_q]    ? mem_a[ra_q]    : init_val(ra_q);
  assign b_mem_rdata = wr_b[rb_q[2]] ? mem_b[rb_q[2]] : init_val(rb_q[2]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if_req = 1'b0; if_addr = '0;
    ex_req = 1'b0; ex_we = 1'b0; ex_addr = '0; ex_wdata = '0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ex_req;
    logic        ex_we;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        exp_if_gnt;
    logic        exp_ex_gnt;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  ex_cnt;
    bit  if_seen;
    bit  rv_seen;

    vecs[0] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,    1'b0};
    vecs[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,    1'b0};
    vecs[2] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0};
    vecs[3] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0,    1'b1};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b0};
    vecs[5] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h5678, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h5678, 1'b1};

    clear_reqs();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst if_gnt",    a_if_gnt,    0);
    check("rst ex_gnt",    a_ex_gnt,    0);
    check("rst if_rvalid", a_if_rvalid, 0);
    check("rst ex_rvalid", a_ex_rvalid, 0);
    check("rst if_rdata",  a_if_rdata,  0);
    check("rst ex_rdata",  a_ex_rdata,  0);
    check("rst mem_re",    a_mem_re,    0);
    check("rst mem_we",    a_mem_we,    0);
    check("rst stall",     a_stall,     0);
    next_cycle();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) next_cycle();

    // Single-cycle arbitration vectors, each applied from IDLE and then drained.
    for (int i = 0; i < 6; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      ex_req = vecs[i].ex_req; ex_we = vecs[i].ex_we;
      ex_addr = vecs[i].ex_addr; ex_wdata = vecs[i].ex_wdata;
      @(negedge clk);
      check($sformatf("vec%0d if_gnt", i),    a_if_gnt,    vecs[i].exp_if_gnt);
      check($sformatf("vec%0d ex_gnt", i),    a_ex_gnt,    vecs[i].exp_ex_gnt);
      check($sformatf("vec%0d mem_re", i),    a_mem_re,    vecs[i].exp_re);
      check($sformatf("vec%0d mem_we", i),    a_mem_we,    vecs[i].exp_we);
      check($sformatf("vec%0d mem_addr", i),  a_mem_addr,  vecs[i].exp_addr);
      check($sformatf("vec%0d mem_wdata", i), a_mem_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d stall", i),     a_stall,     vecs[i].exp_stall);
      next_cycle();
      clear_reqs();
      repeat (5) next_cycle();
    end

    // IF read alone: gnt N, rvalid N+2.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("s1 if_gnt", a_if_gnt, 1);
    next_cycle(); clear_reqs();
    @(negedge clk);
    check("s1 N+1 if_rvalid", a_if_rvalid, 0);
    check("s1 N+1 stall",     a_stall,     1);
    next_cycle();
    @(negedge clk);
    check("s1 N+2 if_rvalid", a_if_rvalid, 1);
    check("s1 N+2 if_rdata",  a_if_rdata,  init_val(8'h10));
    check("s1 N+2 ex_rvalid", a_ex_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("s1 N+3 if_rvalid", a_if_rvalid, 0);
    check("s1 N+3 if_rdata held", a_if_rdata, init_val(8'h10));
    repeat (3) next_cycle();

    // Simultaneous requests: EX first, IF granted in the ex_rvalid cycle.
    if_req = 1'b1; if_addr = 32'h10;
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h40;
    @(negedge clk);
    check("s2 ex_gnt", a_ex_gnt, 1);
    check("s2 if_gnt", a_if_gnt, 0);
    check("s2 stall",  a_stall,  1);
    next_cycle(); ex_req = 1'b0;
    @(negedge clk);
    check("s2 N+1 stall",  a_stall,  1);
    check("s2 N+1 if_gnt", a_if_gnt, 0);
    next_cycle();
    @(negedge clk);
    check("s2 N+2 ex_rvalid", a_ex_rvalid, 1);
    check("s2 N+2 ex_rdata",  a_ex_rdata,  init_val(8'h40));
    check("s2 N+2 if_gnt",    a_if_gnt,    1);
    next_cycle(); clear_reqs();
    next_cycle();
    @(negedge clk);
    check("s2 if_rvalid", a_if_rvalid, 1);
    check("s2 if_rdata",  a_if_rdata,  init_val(8'h10));
    repeat (3) next_cycle();

    // EX write, then IF read next cycle, then EX read-back.
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h80; ex_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("s3 ex_gnt",    a_ex_gnt,    1);
    check("s3 mem_we",    a_mem_we,    1);
    check("s3 mem_addr",  a_mem_addr,  32'h80);
    check("s3 mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    next_cycle(); clear_reqs();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("s3 mem_we one cycle", a_mem_we,    0);
    check("s3 if_gnt",           a_if_gnt,    1);
    check("s3 no ex_rvalid a",   a_ex_rvalid, 0);
    next_cycle(); clear_reqs();
    @(negedge clk);
    check("s3 no ex_rvalid b", a_ex_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("s3 if_rvalid", a_if_rvalid, 1);
    check("s3 no ex_rvalid c", a_ex_rvalid, 0);
    next_cycle();
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h80;
    @(negedge clk);
    check("s3 rd ex_gnt", a_ex_gnt, 1);
    next_cycle(); clear_reqs();
    next_cycle();
    @(negedge clk);
    check("s3 rd ex_rvalid", a_ex_rvalid, 1);
    check("s3 rd ex_rdata",  a_ex_rdata,  32'hDEADBEEF);
    repeat (3) next_cycle();

    // EX read with ex_req dropped during WAIT; IF data must be untouched.
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h40;
    @(negedge clk);
    check("s6 ex_gnt", a_ex_gnt, 1);
    next_cycle(); clear_reqs();
    @(negedge clk);
    check("s6 N+1 ex_rvalid", a_ex_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("s6 ex_rvalid", a_ex_rvalid, 1);
    check("s6 ex_rdata",  a_ex_rdata,  init_val(8'h40));
    check("s6 if_rdata",  a_if_rdata,  init_val(8'h10));
    check("s6 if_rvalid", a_if_rvalid, 0);
    repeat (3) next_cycle();

    // Starvation: EX writes every cycle while IF waits.
    if_req = 1'b1; if_addr = 32'h10;
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h20; ex_wdata = 32'h55;
    ex_cnt = 0;
    if_seen = 1'b0;
    for (int c = 0; c < 10 && !if_seen; c++) begin
      @(negedge clk);
      if (a_if_gnt) if_seen = 1'b1;
      else if (a_ex_gnt) ex_cnt++;
      if (!if_seen) next_cycle();
    end
`ifdef ARB_STARVE_GUARD_EN
    check("s4 ex grants before if", ex_cnt,  4);
    check("s4 if granted",          if_seen, 1);
`else
    check("s4 ex grants",   ex_cnt,  10);
    check("s4 if starved",  if_seen, 0);
`endif
    next_cycle(); clear_reqs();
    repeat (10) next_cycle();

    // MEM_LAT=3 instance: normal reads to load both rdata registers.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("s5 if_gnt", b_if_gnt, 1);
    next_cycle(); clear_reqs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("s5 N+3 if_rvalid", b_if_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("s5 N+4 if_rvalid", b_if_rvalid, 1);
    check("s5 N+4 if_rdata",  b_if_rdata,  init_val(8'h10));
    next_cycle();
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h40;
    @(negedge clk);
    check("s5 ex_gnt", b_ex_gnt, 1);
    next_cycle(); clear_reqs();
    repeat (3) next_cycle();
    @(negedge clk);
    check("s5 ex_rvalid", b_ex_rvalid, 1);
    check("s5 ex_rdata",  b_ex_rdata,  init_val(8'h40));
    repeat (3) next_cycle();

    // Reset asserted in the second WAIT cycle of a read.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("s5r if_gnt", b_if_gnt, 1);
    next_cycle(); clear_reqs();
    next_cycle();
    rst_b = 1'b0;
    #1;
    check("s5r if_rdata cleared", b_if_rdata, 0);
    check("s5r ex_rdata cleared", b_ex_rdata, 0);
    check("s5r stall idle",       b_stall,    0);
    rv_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      if (b_if_rvalid || b_ex_rvalid) rv_seen = 1'b1;
    end
    next_cycle();
    rst_b = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("s5r gnt after release", b_if_gnt, 1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      clear_reqs();
      @(negedge clk);
      if (b_if_rvalid || b_ex_rvalid) rv_seen = 1'b1;
    end
    check("s5r no stray rvalid", rv_seen, 0);
    next_cycle();
    @(negedge clk);
    check("s5r fresh if_rvalid", b_if_rvalid, 1);
    check("s5r fresh if_rdata",  b_if_rdata,  init_val(8'h10));
    repeat (2) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
